// File: rtl/node_eval_pkg.sv
// Shared types and sizing for the decision-tree node evaluator.
// ACC_WIDTH must be >= max(BIAS, FEATURE+COEFF) + $clog2(FEATURES) + 1.
package node_eval_pkg;

   localparam int FEATURES          = 3;
   localparam int FEATURE_BIT_DEPTH = 8;
   localparam int COEFF_BIT_DEPTH   = 4;
   localparam int BIAS_BIT_DEPTH    = 10;
   localparam int ACC_WIDTH         = 16;

   localparam int PROD_WIDTH = FEATURE_BIT_DEPTH + COEFF_BIT_DEPTH;
   localparam int IDX_W      = (FEATURES > 1) ? $clog2(FEATURES) : 1;
   localparam int CNT_W      = $clog2(FEATURES + 1);

   typedef logic signed [FEATURE_BIT_DEPTH-1:0] feature_t;
   typedef logic signed [COEFF_BIT_DEPTH-1:0]   coeff_t;
   typedef logic signed [BIAS_BIT_DEPTH-1:0]    bias_t;
   typedef logic signed [ACC_WIDTH-1:0]         acc_t;
   typedef logic signed [PROD_WIDTH-1:0]        prod_t;
   typedef logic [IDX_W-1:0]                    idx_t;
   typedef logic [CNT_W-1:0]                    cnt_t;

   typedef enum logic [1:0] {
      TERM_ZERO = 2'd0,
      TERM_FEAT = 2'd1,
      TERM_PROD = 2'd2
   } term_sel_e;

   // Signed operands are sign-extended on the way into v, then truncated to ACC_WIDTH.
   function automatic acc_t sext_to_acc(input logic signed [31:0] v);
      return acc_t'(v);
   endfunction

   function automatic idx_t next_idx(input idx_t i);
      if (i == idx_t'(FEATURES - 1)) return '0;
      return idx_t'(i + 1'b1);
   endfunction

endpackage

// File: rtl/node_eval_datapath_if.sv
// Bundle between upstream feature source / tree control FSM (master) and the
// node evaluation datapath (slave).
interface node_eval_if;
   import node_eval_pkg::*;

   feature_t feature_in;
   logic     feature_in_valid;
   logic     feature_in_ready;

   logic     load_bias;
   logic     add;
   logic     mult;
   logic     is_one;
   coeff_t   coeff;
   bias_t    bias;
   logic     vector_done;

   logic     child_direction;
   logic     next;
   logic     underrun;

   modport master (
      output feature_in, feature_in_valid, load_bias, add, mult, is_one,
             coeff, bias, vector_done,
      input  feature_in_ready, child_direction, next, underrun
   );

   modport slave (
      input  feature_in, feature_in_valid, load_bias, add, mult, is_one,
             coeff, bias, vector_done,
      output feature_in_ready, child_direction, next, underrun
   );

endinterface

// File: rtl/node_eval_datapath_dbuf.sv
// Double buffer for feature vectors: staging fills from the serial input while
// the active copy is evaluated; a full staging buffer moves to active on release.
module feature_dbuf
   import node_eval_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  feature_t                 feature_in,
   input  logic                     feature_in_valid,
   output logic                     feature_in_ready,
   input  logic                     vector_done,
   output logic                     active_vld,
   output feature_t [FEATURES-1:0]  active_vec
);

   feature_t [FEATURES-1:0] stage_q, stage_d;
   feature_t [FEATURES-1:0] active_q, active_d;
   cnt_t                    cnt_q, cnt_d;
   logic                    active_vld_q, active_vld_d;

   logic stage_full;
   logic swap;
   logic accept;
   idx_t wr_idx;

   assign stage_full       = (cnt_q == cnt_t'(FEATURES));
   assign feature_in_ready = ~stage_full;
   assign swap             = stage_full & (~active_vld_q | vector_done);
   assign accept           = feature_in_valid & feature_in_ready;

   always_comb begin
      stage_d      = stage_q;
      active_d     = active_q;
      cnt_d        = cnt_q;
      active_vld_d = active_vld_q;
      wr_idx       = swap ? '0 : idx_t'(cnt_q);

      if (swap) begin
         active_d     = stage_q;
         active_vld_d = 1'b1;
         cnt_d        = '0;
      end else if (vector_done) begin
         active_vld_d = 1'b0;
      end

      // A word taken in the swap cycle starts the freshly emptied staging buffer.
      if (accept) begin
         stage_d[wr_idx] = feature_in;
         cnt_d           = swap ? cnt_t'(1) : cnt_t'(cnt_q + 1'b1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q      <= '0;
         active_q     <= '0;
         cnt_q        <= '0;
         active_vld_q <= 1'b0;
      end else begin
         stage_q      <= stage_d;
         active_q     <= active_d;
         cnt_q        <= cnt_d;
         active_vld_q <= active_vld_d;
      end
   end

   assign active_vld = active_vld_q;
   assign active_vec = active_q;

endmodule

// File: rtl/node_eval_datapath.sv
// Evaluates one tree node per pass, acc = bias + sum(coeff_i * feature_i), and
// reports the sign of acc to the control FSM as child_direction.
module node_eval_datapath
   import node_eval_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   node_eval_if.slave bus
);

   feature_t [FEATURES-1:0] active_vec;
   logic                    active_vld;

   feature_dbuf u_dbuf (
      .clk              (clk),
      .reset            (reset),
      .feature_in       (bus.feature_in),
      .feature_in_valid (bus.feature_in_valid),
      .feature_in_ready (bus.feature_in_ready),
      .vector_done      (bus.vector_done),
      .active_vld       (active_vld),
      .active_vec       (active_vec)
   );

   acc_t      acc_q, acc_d;
   idx_t      feat_idx_q, feat_idx_d;
   logic      underrun_q, underrun_d;

   feature_t  cur_feat;
   prod_t     product;
   term_sel_e term_sel;
   acc_t      term;
   acc_t      acc_base;

   assign cur_feat = active_vec[feat_idx_q];
   assign product  = cur_feat * bus.coeff;

   // is_one wins over mult so the FSM can skip the multiplier for unit weights.
   always_comb begin
      term_sel = TERM_ZERO;
      if (bus.is_one) begin
         term_sel = TERM_FEAT;
      end else if (bus.mult) begin
         term_sel = TERM_PROD;
      end

      case (term_sel)
         TERM_FEAT: term = sext_to_acc(cur_feat);
         TERM_PROD: term = sext_to_acc(product);
         default:   term = '0;
      endcase
   end

   always_comb begin
      acc_d      = acc_q;
      feat_idx_d = feat_idx_q;
      underrun_d = underrun_q;
      acc_base   = bus.load_bias ? sext_to_acc(bus.bias) : acc_q;

      if (bus.add) begin
         if (active_vld) begin
            acc_d      = acc_base + term;
            feat_idx_d = bus.load_bias ? next_idx('0) : next_idx(feat_idx_q);
         end else begin
            underrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q      <= '0;
         feat_idx_q <= '0;
         underrun_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         feat_idx_q <= feat_idx_d;
         underrun_q <= underrun_d;
      end
   end

   assign bus.child_direction = ~acc_q[ACC_WIDTH-1];
   assign bus.next            = active_vld;
   assign bus.underrun        = underrun_q;

endmodule

// File: tb/tb_node_eval_datapath.sv
// Directed and randomized checks of node_eval_datapath against a plain-arithmetic
// model of buffering and node evaluation.
module tb_node_eval_datapath;
   import node_eval_pkg::*;

   logic clk = 1'b0;
   logic reset;

   node_eval_if bus ();

   node_eval_datapath dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int fails     = 0;
   int act_f[3];
   int last_dir;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.add         = 1'b0;
      bus.load_bias   = 1'b0;
      bus.mult        = 1'b0;
      bus.is_one      = 1'b0;
      bus.coeff       = '0;
      bus.bias        = '0;
      bus.vector_done = 1'b0;
   endtask

   task automatic push_vec(input int f0, input int f1, input int f2);
      int f[3];
      f[0] = f0; f[1] = f1; f[2] = f2;
      for (int k = 0; k < 3; k++) begin
         bus.feature_in       = feature_t'(f[k]);
         bus.feature_in_valid = 1'b1;
         check("push_ready", {31'd0, bus.feature_in_ready}, 32'd1);
         step();
      end
      bus.feature_in_valid = 1'b0;
      bus.feature_in       = '0;
   endtask

   task automatic pulse_done();
      bus.vector_done = 1'b1;
      step();
      bus.vector_done = 1'b0;
   endtask

   // Each term: mode bit0 = is_one, bit1 = mult; expected acc is plain integer math.
   task automatic eval_node(input string tag, input int b,
                            input int m0, input int c0, input int m1, input int c1,
                            input int m2, input int c2);
      int m[3];
      int c[3];
      int acc;
      int term;
      m[0] = m0; m[1] = m1; m[2] = m2;
      c[0] = c0; c[1] = c1; c[2] = c2;
      acc = b;
      for (int k = 0; k < 3; k++) begin
         bus.add       = 1'b1;
         bus.load_bias = (k == 0);
         bus.bias      = bias_t'(b);
         bus.is_one    = (m[k] & 1) != 0;
         bus.mult      = (m[k] & 2) != 0;
         bus.coeff     = coeff_t'(c[k]);
         if ((m[k] & 1) != 0)      term = act_f[k];
         else if ((m[k] & 2) != 0) term = act_f[k] * c[k];
         else                      term = 0;
         acc += term;
         step();
      end
      idle();
      last_dir = (acc >= 0) ? 1 : 0;
      check(tag, {31'd0, bus.child_direction}, 32'(last_dir));
   endtask

   function automatic int rnd(input int lo, input int hi);
      return lo + int'($urandom_range(hi - lo));
   endfunction

   initial begin
      reset                = 1'b1;
      bus.feature_in       = '0;
      bus.feature_in_valid = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready",    {31'd0, bus.feature_in_ready}, 32'd1);
      check("rst_dir",      {31'd0, bus.child_direction},  32'd1);
      check("rst_next",     {31'd0, bus.next},             32'd0);
      check("rst_underrun", {31'd0, bus.underrun},         32'd0);
      reset = 1'b0;
      step();

      // Test 1
      push_vec(10, -3, 5);
      check("t1_full_ready", {31'd0, bus.feature_in_ready}, 32'd0);
      step();
      check("t1_next",  {31'd0, bus.next},             32'd1);
      check("t1_ready", {31'd0, bus.feature_in_ready}, 32'd1);
      act_f = '{10, -3, 5};
      eval_node("t1_dir", -20, 1, 0, 2, 2, 2, -1);
      check("t1_dir_abs", {31'd0, bus.child_direction}, 32'd0);

      // Test 2: positive, exactly zero, and minus one
      eval_node("t2_pos",  30, 1, 0, 2, 2, 2, -1);
      eval_node("t2_zero",  1, 1, 0, 2, 2, 2, -1);
      eval_node("t2_neg1",  0, 1, 0, 2, 2, 2, -1);

      // Test 3: skipped term, then is_one priority over mult
      eval_node("t3_skip", -20, 1, 0, 0, 0, 2, -1);
      eval_node("t3_prio", -10, 3, -8, 0, 0, 0, 0);

      // Test 4: stage a second vector during evaluation, swap on vector_done
      push_vec(-50, 7, 100);
      check("t4_ready_low", {31'd0, bus.feature_in_ready}, 32'd0);
      step();
      check("t4_hold_ready", {31'd0, bus.feature_in_ready}, 32'd0);
      check("t4_hold_next",  {31'd0, bus.next},             32'd1);
      pulse_done();
      check("t4_swap_next",  {31'd0, bus.next},             32'd1);
      check("t4_swap_ready", {31'd0, bus.feature_in_ready}, 32'd1);
      act_f = '{-50, 7, 100};
      eval_node("t4_eval_pos",   0, 2, 1, 2, 1, 2, 1);
      eval_node("t4_eval_neg", -60, 2, 1, 2, 1, 2, 1);

      // Test 5: release with nothing staged, then underrun
      pulse_done();
      check("t5_next", {31'd0, bus.next}, 32'd0);
      bus.add       = 1'b1;
      bus.load_bias = 1'b1;
      bus.is_one    = 1'b1;
      bus.bias      = bias_t'(500);
      step();
      idle();
      check("t5_underrun", {31'd0, bus.underrun},        32'd1);
      check("t5_acc_hold", {31'd0, bus.child_direction}, 32'(last_dir));
      repeat (3) step();
      check("t5_sticky",   {31'd0, bus.underrun},        32'd1);

      // Test 6: asynchronous reset between add cycles 2 and 3
      push_vec(10, -3, 5);
      step();
      check("t6_next", {31'd0, bus.next}, 32'd1);
      bus.add = 1'b1; bus.load_bias = 1'b1; bus.is_one = 1'b1; bus.bias = bias_t'(-20);
      step();
      bus.load_bias = 1'b0; bus.is_one = 1'b0; bus.mult = 1'b1; bus.coeff = coeff_t'(2);
      step();
      #2 reset = 1'b1;
      #1;
      check("t6_dir",      {31'd0, bus.child_direction},  32'd1);
      check("t6_next_clr", {31'd0, bus.next},             32'd0);
      check("t6_ready",    {31'd0, bus.feature_in_ready}, 32'd1);
      check("t6_underrun", {31'd0, bus.underrun},         32'd0);
      idle();
      reset = 1'b0;
      step();
      push_vec(10, -3, 5);
      step();
      act_f = '{10, -3, 5};
      eval_node("t6_rerun", -20, 1, 0, 2, 2, 2, -1);

      // Randomized vectors and nodes
      for (int it = 0; it < 12; it++) begin
         int nf[3];
         for (int k = 0; k < 3; k++) nf[k] = rnd(-128, 127);
         push_vec(nf[0], nf[1], nf[2]);
         check("rnd_ready_low", {31'd0, bus.feature_in_ready}, 32'd0);
         pulse_done();
         check("rnd_next", {31'd0, bus.next}, 32'd1);
         act_f = nf;
         for (int n = 0; n < 2; n++) begin
            eval_node("rnd_dir", rnd(-512, 511),
                      rnd(0, 3), rnd(-8, 7), rnd(0, 3), rnd(-8, 7),
                      rnd(0, 3), rnd(-8, 7));
         end
      end
      check("end_underrun", {31'd0, bus.underrun}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
